// File: rtl/scratch_fill_controller.sv
// Scratchpad fill controller: moves words from per-channel input buffers into
// circular scratchpads, tracks occupancy and signals when a multiply window is ready.
module scratch_fill_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 4,
  parameter int CELL_NUMS  = 8,
  parameter int NUM_CH     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic [NUM_CH-1:0]               buf_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    buf_dout,
  output logic [NUM_CH-1:0]               buf_ren,
  output logic [NUM_CH-1:0]               scratch_wen,
  output logic [NUM_CH*ADDR_SIZE-1:0]     scratch_waddr,
  output logic [NUM_CH*DATA_WIDTH-1:0]    scratch_din,
  input  logic [NUM_CH*(ADDR_SIZE+1)-1:0] free_cnt,
  input  logic [ADDR_SIZE:0]              window_size,
  output logic [NUM_CH*ADDR_SIZE-1:0]     last_write,
  output logic [NUM_CH*(ADDR_SIZE+1)-1:0] fill_level,
  output logic [NUM_CH-1:0]               full,
  output logic                            can_mult,
  output logic                            done,
  output logic                            underflow_err
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(CELL_NUMS - 1);
  localparam logic [ADDR_SIZE:0]   CELLS     = (ADDR_SIZE+1)'(CELL_NUMS);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;

  state_t                 state, state_next;
  logic [ADDR_SIZE-1:0]   wr_ptr    [NUM_CH];
  logic [ADDR_SIZE-1:0]   last_wr   [NUM_CH];
  logic [ADDR_SIZE:0]     fill      [NUM_CH];
  logic [ADDR_SIZE:0]     fill_next [NUM_CH];
  logic [ADDR_SIZE+1:0]   fill_sum  [NUM_CH];
  logic [ADDR_SIZE+1:0]   free_ext  [NUM_CH];
  logic [NUM_CH-1:0]      wen;
  logic [NUM_CH-1:0]      uf_hit;
  logic                   all_empty;
  logic                   window_ok;
  logic                   done_q;
  logic                   underflow_q;

  // Per-channel datapath: write gating, occupancy arithmetic and output packing.
  always_comb begin
    full          = '0;
    wen           = '0;
    uf_hit        = '0;
    all_empty     = 1'b1;
    window_ok     = 1'b1;
    scratch_waddr = '0;
    scratch_din   = '0;
    last_write    = '0;
    fill_level    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c] = (fill[c] == CELLS);
      wen[c]  = (state == ACTIVE) & buf_valid[c] & ~full[c];
      if (fill[c] != '0) all_empty = 1'b0;
      if (fill[c] < window_size) window_ok = 1'b0;
      // Over-release saturates at zero rather than wrapping.
      fill_sum[c]  = {1'b0, fill[c]} + {{(ADDR_SIZE+1){1'b0}}, wen[c]};
      free_ext[c]  = {1'b0, free_cnt[c*(ADDR_SIZE+1) +: (ADDR_SIZE+1)]};
      uf_hit[c]    = free_ext[c] > fill_sum[c];
      fill_next[c] = uf_hit[c] ? '0 : (ADDR_SIZE+1)'(fill_sum[c] - free_ext[c]);
      scratch_waddr[c*ADDR_SIZE +: ADDR_SIZE]     = wr_ptr[c];
      scratch_din[c*DATA_WIDTH +: DATA_WIDTH]     = buf_dout[c*DATA_WIDTH +: DATA_WIDTH];
      last_write[c*ADDR_SIZE +: ADDR_SIZE]        = last_wr[c];
      fill_level[c*(ADDR_SIZE+1) +: (ADDR_SIZE+1)] = fill[c];
    end
    buf_ren       = wen;
    scratch_wen   = wen;
    can_mult      = (state != IDLE) & window_ok & (window_size != '0);
    done          = done_q;
    underflow_err = underflow_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ACTIVE;
      ACTIVE:  if (stop)      state_next = FLUSH;
      FLUSH:   if (all_empty) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // A start accepted in IDLE begins a fresh pass with all bookkeeping cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]  <= '0;
        last_wr[c] <= '0;
        fill[c]    <= '0;
      end
    end else begin
      state  <= state_next;
      done_q <= (state == FLUSH) & all_empty;
      if (state == IDLE && start) begin
        underflow_q <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
          wr_ptr[c]  <= '0;
          last_wr[c] <= '0;
          fill[c]    <= '0;
        end
      end else begin
        underflow_q <= underflow_q | (|uf_hit);
        for (int c = 0; c < NUM_CH; c++) begin
          fill[c] <= fill_next[c];
          if (wen[c]) begin
            last_wr[c] <= wr_ptr[c];
            wr_ptr[c]  <= (wr_ptr[c] == LAST_ADDR) ? '0 : wr_ptr[c] + ADDR_SIZE'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/scratch_fill_controller.md
SCRATCH_FILL_CONTROLLER -- requirements
Module: scratch_fill_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, scratchpad cell width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, scratchpad address width.
REQ-003 SHALL have parameter CELL_NUMS, default 8, cells per channel, 2 <= CELL_NUMS <= 2^ADDR_SIZE, not required to be a power of two.
REQ-004 SHALL have parameter NUM_CH, default 2, independent channels (ch0 = ifmap, ch1 = filter, further channels generic).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begins a pass; honoured only in IDLE.
REQ-008 SHALL have port stop  input  1  end of input data; honoured only in ACTIVE.
REQ-009 SHALL have port buf_valid  input  NUM_CH  per-channel input buffer non-empty (first-word-fall-through).
REQ-010 SHALL have port buf_dout  input  NUM_CH*DATA_WIDTH  per-channel buffer head word, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port buf_ren  output  NUM_CH  per-channel buffer pop.
REQ-012 SHALL have port scratch_wen  output  NUM_CH  per-channel scratchpad write enable.
REQ-013 SHALL have port scratch_waddr  output  NUM_CH*ADDR_SIZE  per-channel write address.
REQ-014 SHALL have port scratch_din  output  NUM_CH*DATA_WIDTH  per-channel write data.
REQ-015 SHALL have port free_cnt  input  NUM_CH*(ADDR_SIZE+1)  cells released by consumer this cycle, per channel.
REQ-016 SHALL have port window_size  input  ADDR_SIZE+1  cells required in every channel before multiply.
REQ-017 SHALL have port last_write  output  NUM_CH*ADDR_SIZE  address of most recent write per channel.
REQ-018 SHALL have port fill_level  output  NUM_CH*(ADDR_SIZE+1)  occupied cells per channel.
REQ-019 SHALL have port full  output  NUM_CH  fill_level == CELL_NUMS per channel.
REQ-020 SHALL have port can_mult  output  1  window available in all channels.
REQ-021 SHALL have port done  output  1  one-cycle pass-complete pulse.
REQ-022 SHALL have port underflow_err  output  1  sticky over-release flag.

Function
REQ-023 SHALL implement FSM IDLE/ACTIVE/FLUSH: IDLE->ACTIVE on start; ACTIVE->FLUSH on stop; FLUSH->IDLE when every fill_level == 0.
REQ-024 SHALL, on start accepted in IDLE, clear all write pointers, fill levels, last_write and underflow_err in the same edge.
REQ-025 SHALL drive buf_ren[c] = (state==ACTIVE) & buf_valid[c] & ~full[c], combinationally from registered state.
REQ-026 SHALL drive scratch_wen[c] = buf_ren[c], scratch_waddr[c] = wr_ptr[c], scratch_din[c] = buf_dout[c], zero-latency pass-through.
REQ-027 SHALL, per write, set last_write[c] <= wr_ptr[c] and advance wr_ptr[c] by 1, wrapping CELL_NUMS-1 -> 0.
REQ-028 SHALL update fill_level[c] <= fill_level[c] + wen[c] - free_cnt[c] in one edge when write and release coincide.
REQ-029 SHALL, if free_cnt[c] > fill_level[c] + wen[c], saturate fill_level[c] to 0 and set underflow_err until rst or start.
REQ-030 SHALL accept free_cnt in every state; writes occur only in ACTIVE.
REQ-031 SHALL drive can_mult = (state != IDLE) & (fill_level[c] >= window_size for all c) & (window_size != 0).
REQ-032 SHALL ignore start outside IDLE and stop outside ACTIVE; start and stop together in IDLE -> ACTIVE only.
REQ-033 SHALL pulse done for exactly one cycle on the FLUSH->IDLE transition edge.
REQ-034 SHALL, if stop arrives with all fill levels already 0, pass through FLUSH for one cycle then IDLE with done.

Reset
REQ-035 SHALL, on rst high at a rising edge, set state IDLE, wr_ptr/last_write/fill_level 0, underflow_err 0, done 0, overriding start/stop/free_cnt, including mid-pass.
REQ-036 SHALL, while rst is asserted, hold buf_ren, scratch_wen, full and can_mult at 0 (follow from IDLE and zero fill).

Verification
REQ-037 SHALL cover fill: start, ch0/ch1 buf_valid=1 for 8 cycles, window_size=4 -> addresses 0..7 written, can_mult high from cycle 5, full=2'b11, buf_ren=0 thereafter.
REQ-038 SHALL cover wrap: full ch0, free_cnt=3, then 3 writes -> waddr 0,1,2, last_write=2, fill_level=8.
REQ-039 SHALL cover simultaneous write+release: fill=5, wen=1, free_cnt=1 -> fill stays 5, can_mult unchanged.
REQ-040 SHALL cover over-release: fill=2, free_cnt=4 -> fill=0, underflow_err=1, cleared by next start.
REQ-041 SHALL cover flush: stop with fills 3/3, free_cnt=3 next cycle -> IDLE after 1 cycle, done pulses once, no writes after stop.
REQ-042 SHALL cover mid-pass reset: rst during ACTIVE with fill=6 -> all outputs 0, state IDLE, start then restarts at address 0.
